// File: rtl/data_mem_pkg.sv
// rtl/data_mem_pkg.sv - shared types and helpers for the data memory arbiter
package data_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam int MEM_BYTES_DEF = 64;

  typedef logic port_t;

  // Legal means doubleword aligned with all eight bytes inside the memory.
  function automatic logic addr_legal(input logic [63:0] addr, input int mem_bytes);
    return (addr[2:0] == 3'b000) && (addr <= 64'(mem_bytes - 8));
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-requester round-robin grant, combinational
module rr_arbiter2
  import data_mem_pkg::*;
(
  input  logic [1:0] req,
  input  port_t      last_grant,
  output logic [1:0] gnt
);

  // On a tie the port that did not win last time goes next.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_grant == 1'b1) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - serialises MEM-stage and loader access to the data memory
module data_mem_arbiter
  import data_mem_pkg::*;
#(
  parameter int MEM_BYTES = MEM_BYTES_DEF,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [1:0]           req_write,
  input  logic [63:0]          req_addr0,
  input  logic [63:0]          req_addr1,
  input  logic [63:0]          req_wdata0,
  input  logic [63:0]          req_wdata1,
  output logic [1:0]           rsp_valid,
  input  logic [1:0]           rsp_ready,
  output logic [63:0]          rsp_rdata,
  output logic                 rsp_err,
  output logic [63:0]          mem_addr,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [63:0]          mem_wdata,
  input  logic [63:0]          mem_rdata,
  output logic [ERR_CNT_W-1:0] err_count
);

  state_t               r_state;
  port_t                r_port;
  port_t                r_last_grant;
  logic                 r_write;
  logic [63:0]          r_addr;
  logic [63:0]          r_wdata;
  logic [63:0]          r_rdata;
  logic                 r_err;
  logic [ERR_CNT_W-1:0] r_err_count;

  logic [1:0]           w_gnt;
  port_t                w_win;
  logic                 w_hs;
  logic                 w_legal;
  logic                 w_access;

  rr_arbiter2 u_arb (
    .req        (req_valid),
    .last_grant (r_last_grant),
    .gnt        (w_gnt)
  );

  assign w_win    = w_gnt[1];
  assign w_hs     = (r_state == IDLE) && (w_gnt != 2'b00);
  assign w_legal  = addr_legal(r_addr, MEM_BYTES);
  assign w_access = (r_state == ACCESS);

  assign req_ready = (r_state == IDLE) ? w_gnt : 2'b00;
  assign rsp_valid = (r_state == RESP) ? (r_port ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;
  assign err_count = r_err_count;

  // Memory strobes decode straight from the state register so an async reset
  // kills an in-flight write before the next edge can commit it.
  assign mem_addr  = w_access ? r_addr : 64'd0;
  assign mem_read  = w_access && !r_write && w_legal;
  assign mem_write = w_access && r_write && w_legal;
  assign mem_wdata = mem_write ? r_wdata : 64'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_port       <= 1'b0;
      r_last_grant <= 1'b1;
      r_write      <= 1'b0;
      r_addr       <= 64'd0;
      r_wdata      <= 64'd0;
      r_rdata      <= 64'd0;
      r_err        <= 1'b0;
      r_err_count  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_hs) begin
            r_port       <= w_win;
            r_last_grant <= w_win;
            r_write      <= req_write[w_win];
            r_addr       <= w_win ? req_addr1 : req_addr0;
            r_wdata      <= w_win ? req_wdata1 : req_wdata0;
            r_state      <= ACCESS;
          end
        end
        ACCESS: begin
          r_rdata <= mem_read ? mem_rdata : 64'd0;
          r_err   <= !w_legal;
          if (!w_legal && (r_err_count != '1)) begin
            r_err_count <= r_err_count + ERR_CNT_W'(1);
          end
          r_state <= RESP;
        end
        RESP: begin
          if (rsp_ready[r_port]) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - scoreboard bench for data_mem_arbiter
module tb_data_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic [1:0]  req_write = 2'b00;
  logic [63:0] p_addr [2];
  logic [63:0] p_wdata [2];
  logic [63:0] req_addr0, req_addr1, req_wdata0, req_wdata1;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready = 2'b00;
  logic [63:0] rsp_rdata;
  logic        rsp_err;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write;
  logic [7:0]  err_count;

  assign req_addr0  = p_addr[0];
  assign req_addr1  = p_addr[1];
  assign req_wdata0 = p_wdata[0];
  assign req_wdata1 = p_wdata[1];

  always #5 clk = ~clk;

  data_mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .err_count(err_count)
  );

  // Memory device driven by the DUT, and the model's own view of memory.
  logic [7:0] dev_mem [64];
  logic [7:0] shadow [64];

  always_comb begin
    mem_rdata = '0;
    for (int k = 0; k < 8; k++) mem_rdata[8*k +: 8] = dev_mem[(int'(mem_addr[5:0]) + k) & 63];
  end

  always @(posedge clk) begin
    if (mem_write) begin
      for (int k = 0; k < 8; k++) dev_mem[(int'(mem_addr[5:0]) + k) & 63] <= mem_wdata[8*k +: 8];
    end
  end

  typedef struct {
    int          port;
    logic        wr;
    logic [63:0] addr;
    logic [63:0] wdata;
  } txn_t;

  txn_t        q[$];
  int          grant_log[$];
  int          checks = 0;
  int          errors = 0;
  int          m_phase = 0;
  int          m_last = 1;
  int          model_err = 0;
  logic [1:0]  acc = 2'b00;
  logic [63:0] last_rdata = '0;
  logic        rand_en = 1'b0, rand_rsp = 1'b0, rand_legal = 1'b0;
  int          gen_pct = 0;

  function automatic logic legal(input logic [63:0] a);
    return (a % 8 == 0) && (a <= 64 - 8);
  endfunction

  function automatic logic [63:0] shadow_word(input logic [63:0] a);
    logic [63:0] w = 0;
    for (int k = 7; k >= 0; k--) w = (w << 8) + 64'(shadow[(int'(a) + k) % 64]);
    return w;
  endfunction

  function automatic logic [63:0] dev_word(input logic [63:0] a);
    logic [63:0] w = 0;
    for (int k = 7; k >= 0; k--) w = (w << 8) + 64'(dev_mem[(int'(a) + k) % 64]);
    return w;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready), 0);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
    chk({tag, "_rsp_err"}, 64'(rsp_err), 0);
    chk({tag, "_mem_en"}, 64'({mem_read, mem_write}), 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_err_count"}, 64'(err_count), 0);
  endtask

  // Monitor / scoreboard: tracks the transaction life cycle at the abstract level.
  initial begin : monitor
    txn_t       t;
    logic [1:0] exp_rdy;
    logic [1:0] hs;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
        m_phase = 0; m_last = 1; model_err = 0; acc = 2'b00;
      end else begin
        exp_rdy = 2'b00;
        if (m_phase == 0) begin
          if (req_valid == 2'b01) exp_rdy = 2'b01;
          else if (req_valid == 2'b10) exp_rdy = 2'b10;
          else if (req_valid == 2'b11) exp_rdy = (m_last == 0) ? 2'b10 : 2'b01;
        end
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        chk("err_count", 64'(err_count), 64'(model_err));
        if (m_phase == 1) begin
          t = q[0];
          chk("access_rsp_valid", 64'(rsp_valid), 0);
          chk("mem_addr", mem_addr, t.addr);
          chk("mem_read", 64'(mem_read), 64'(!t.wr && legal(t.addr)));
          chk("mem_write", 64'(mem_write), 64'(t.wr && legal(t.addr)));
          if (t.wr && legal(t.addr)) chk("mem_wdata", mem_wdata, t.wdata);
          if (!legal(t.addr) && model_err < 255) model_err++;
          m_phase = 2;
        end else begin
          chk("idle_mem_en", 64'({mem_read, mem_write}), 0);
          chk("idle_mem_bus", mem_addr | mem_wdata, 0);
          if (m_phase == 0) begin
            chk("idle_rsp_valid", 64'(rsp_valid), 0);
            hs = req_valid & req_ready;
            if (hs != 2'b00) begin
              t.port  = hs[0] ? 0 : 1;
              t.wr    = req_write[t.port];
              t.addr  = p_addr[t.port];
              t.wdata = p_wdata[t.port];
              q.push_back(t);
              grant_log.push_back(t.port);
              acc[t.port] = 1'b1;
              m_last = t.port;
              m_phase = 1;
            end
          end else begin
            t = q[0];
            chk("rsp_valid", 64'(rsp_valid), (t.port == 0) ? 64'd1 : 64'd2);
            chk("rsp_err", 64'(rsp_err), 64'(!legal(t.addr)));
            chk("rsp_rdata", rsp_rdata, (t.wr || !legal(t.addr)) ? 64'd0 : shadow_word(t.addr));
            if (rsp_ready[t.port]) begin
              if (t.wr && legal(t.addr))
                for (int k = 0; k < 8; k++) shadow[int'(t.addr) + k] = t.wdata[8*k +: 8];
              last_rdata = rsp_rdata;
              void'(q.pop_front());
              m_phase = 0;
            end
          end
        end
      end
    end
  end

  task automatic new_req(input int p, input logic wr, input logic [63:0] a, input logic [63:0] d);
    p_addr[p] = a; p_wdata[p] = d; req_write[p] = wr; req_valid[p] = 1'b1;
  endtask

  initial begin : rand_driver
    logic [63:0] a;
    forever begin
      @(posedge clk); #1;
      if (rand_en) begin
        for (int p = 0; p < 2; p++) begin
          if (acc[p]) begin acc[p] = 1'b0; req_valid[p] = 1'b0; end
          if (!req_valid[p] && $urandom_range(99) < gen_pct) begin
            if (rand_legal || $urandom_range(9) < 7) a = 64'(8 * $urandom_range(7));
            else a = 64'($urandom_range(70));
            new_req(p, 1'($urandom_range(1)), a, {$urandom, $urandom});
          end
        end
        if (rand_rsp) rsp_ready = 2'($urandom_range(3));
      end
    end
  end

  task automatic wait_acc(input int p);
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (acc[p]) begin acc[p] = 1'b0; req_valid[p] = 1'b0; return; end
    end
    chk("accept_timeout", 1, 0);
    req_valid[p] = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (m_phase == 0 && q.size() == 0) return;
    end
    chk("idle_timeout", 1, 0);
  endtask

  task automatic issue(input int p, input logic wr, input logic [63:0] a, input logic [63:0] d);
    new_req(p, wr, a, d);
    wait_acc(p);
  endtask

  task automatic stop_rand();
    @(posedge clk); #2;
    rand_en = 1'b0; req_valid = 2'b00; acc = 2'b00;
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    for (int i = 0; i < 64; i++) begin
      dev_mem[i] = 8'($urandom);
      shadow[i]  = dev_mem[i];
    end
    p_addr[0] = 0; p_addr[1] = 0; p_wdata[0] = 0; p_wdata[1] = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");

    // Both ports valid out of reset: grants must alternate starting with port 0.
    rsp_ready = 2'b11; rand_legal = 1'b1; gen_pct = 100; rand_rsp = 1'b0;
    new_req(0, 1'b0, 64'd0, 64'd0);
    new_req(1, 1'b0, 64'd8, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    rand_en = 1'b1;
    for (int i = 0; i < 100 && grant_log.size() < 4; i++) @(posedge clk);
    stop_rand();
    wait_idle();
    for (int i = 0; i < 4; i++) chk($sformatf("tie_grant%0d", i), 64'(grant_log[i]), 64'(i % 2));

    // Store then load through port 0.
    issue(0, 1'b1, 64'd8, 64'h1122334455667788);
    wait_idle();
    issue(0, 1'b0, 64'd8, 64'd0);
    wait_idle();
    chk("store_load_data", last_rdata, 64'h1122334455667788);

    // Out-of-range store and misaligned load.
    issue(0, 1'b1, 64'd60, 64'hA5A5A5A5A5A5A5A5);
    wait_idle();
    issue(0, 1'b0, 64'd3, 64'd0);
    wait_idle();
    chk("illegal_err_count", 64'(err_count), 64'd2);

    // Response backpressure on port 1 while port 0 waits.
    rsp_ready = 2'b01;
    issue(1, 1'b0, 64'd16, 64'd0);
    new_req(0, 1'b0, 64'd24, 64'd0);
    repeat (6) @(negedge clk);
    chk("bp_port0_held", 64'(req_ready), 0);
    @(posedge clk); #1;
    rsp_ready = 2'b11;
    wait_acc(0);
    wait_idle();

    // Randomised traffic with random response backpressure.
    rand_legal = 1'b0; gen_pct = 40; rand_rsp = 1'b1; rand_en = 1'b1;
    repeat (600) @(posedge clk);
    stop_rand();
    rsp_ready = 2'b11;
    wait_idle();

    // Error counter saturation.
    for (int i = 0; i < 260; i++) issue(0, 1'($urandom_range(1)), 64'(8 * $urandom_range(7) + 1), 64'd0);
    wait_idle();
    chk("err_saturated", 64'(err_count), 64'd255);

    // Reset while a store is in ACCESS.
    new_req(0, 1'b1, 64'd16, 64'hDEADBEEFCAFEF00D);
    wait_acc(0);
    #1;
    chk("mid_store_mem_write", 64'(mem_write), 1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("mid_reset");
    @(posedge clk); #1;
    chk("mid_reset_addr16", dev_word(64'd16), shadow_word(64'd16));
    rst_n = 1'b1;
    issue(0, 1'b0, 64'd16, 64'd0);
    wait_idle();

    for (int i = 0; i < 64; i++) chk($sformatf("final_mem%0d", i), 64'(dev_mem[i]), 64'(shadow[i]));
    chk("queue_empty", 64'(q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
